// File: rtl/mux_selftest_ctrl.sv
// Built-in self-test sequencer for a 2:1 mux with a 9-wire observation bus.
// Walks all eight {I0,I1,S} vectors, compares against a golden bus, accumulates a fault mask.
module mux_selftest_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter bit          STOP_ON_FAIL  = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [8:0] dut_out_i,
    output logic       dut_i0_o,
    output logic       dut_i1_o,
    output logic       dut_s_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       pass_o,
    output logic [8:0] fail_mask_o,
    output logic [2:0] first_fail_vec_o,
    output logic [2:0] vec_idx_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_e;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

    state_e     state_q;
    logic [2:0] vec_q;
    logic [3:0] cnt_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;
    logic [8:0] fail_mask_q;
    logic [2:0] first_fail_q;

    logic [8:0] golden;
    logic [8:0] mism;
    logic [8:0] fail_mask_d;
    logic       any_mism;
    logic       stop_now;

    // Golden bus for the vector on the stimulus pins: {I0,I1,S} = vec_q[2:0].
    always_comb begin
        golden      = '0;
        golden[0]   = vec_q[2];
        golden[1]   = vec_q[1];
        golden[2]   = vec_q[0];
        golden[3]   = vec_q[0];
        golden[4]   = vec_q[0];
        golden[5]   = ~vec_q[0];
        golden[6]   = vec_q[1] & vec_q[0];
        golden[7]   = vec_q[2] & ~vec_q[0];
        golden[8]   = golden[6] | golden[7];
        mism        = dut_out_i ^ golden;
        any_mism    = |mism;
        fail_mask_d = fail_mask_q | mism;
        stop_now    = (vec_q == 3'd7) || (STOP_ON_FAIL && any_mism);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            vec_q        <= '0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_mask_q  <= '0;
            first_fail_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        fail_mask_q  <= '0;
                        pass_q       <= 1'b0;
                        first_fail_q <= '0;
                        cnt_q        <= SETTLE_LD;
                        busy_q       <= 1'b1;
                        state_q      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd1) begin
                        state_q <= S_CHECK;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_CHECK: begin
                    fail_mask_q <= fail_mask_d;
                    // An all-zero mask so far means this is the first failing vector.
                    if (any_mism && (fail_mask_q == '0)) begin
                        first_fail_q <= vec_q;
                    end
                    if (stop_now) begin
                        done_q  <= 1'b1;
                        pass_q  <= (fail_mask_d == '0);
                        state_q <= S_DONE;
                    end else begin
                        vec_q   <= vec_q + 3'd1;
                        cnt_q   <= SETTLE_LD;
                        state_q <= S_WAIT;
                    end
                end
                S_DONE: begin
                    vec_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dut_i0_o         = vec_q[2];
    assign dut_i1_o         = vec_q[1];
    assign dut_s_o          = vec_q[0];
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign fail_mask_o      = fail_mask_q;
    assign first_fail_vec_o = first_fail_q;
    assign vec_idx_o        = vec_q;

endmodule

// File: tb/tb_mux_selftest_ctrl.sv
// Bench for mux_selftest_ctrl: a behavioural mux with stuck-at fault injection drives
// dut_out; each run is checked cycle by cycle against expectations from a vector-level model.
module tb_mux_selftest_ctrl;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_a = 1'b0, start_b = 1'b0;
    logic [8:0] out_a, out_b;
    logic       a_i0, a_i1, a_s, a_busy, a_done, a_pass;
    logic       b_i0, b_i1, b_s, b_busy, b_done, b_pass;
    logic [8:0] a_mask, b_mask;
    logic [2:0] a_first, b_first, a_vec, b_vec;

    logic [8:0] sa0 = '0, sa1 = '0;
    bit         sel = 1'b0;
    int         checks = 0, errors = 0;

    logic       m_busy, m_done, m_pass;
    logic [8:0] m_mask;
    logic [2:0] m_first, m_vec, m_stim;

    always #5 clk = ~clk;

    mux_selftest_ctrl #(.SETTLE_CYCLES(S), .STOP_ON_FAIL(1'b0)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start_a), .dut_out_i(out_a),
        .dut_i0_o(a_i0), .dut_i1_o(a_i1), .dut_s_o(a_s), .busy_o(a_busy),
        .done_o(a_done), .pass_o(a_pass), .fail_mask_o(a_mask),
        .first_fail_vec_o(a_first), .vec_idx_o(a_vec));

    mux_selftest_ctrl #(.SETTLE_CYCLES(S), .STOP_ON_FAIL(1'b1)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start_b), .dut_out_i(out_b),
        .dut_i0_o(b_i0), .dut_i1_o(b_i1), .dut_s_o(b_s), .busy_o(b_busy),
        .done_o(b_done), .pass_o(b_pass), .fail_mask_o(b_mask),
        .first_fail_vec_o(b_first), .vec_idx_o(b_vec));

    // Fault-free mux_proper observation bus: out, I0&~S, I1&S, ~S, S x3, I1, I0.
    function automatic logic [8:0] mux_obs(input logic i0, input logic i1, input logic s);
        logic y;
        y = s ? i1 : i0;
        return {y, i0 & ~s, i1 & s, ~s, s, s, s, i1, i0};
    endfunction

    always_comb begin
        out_a = (mux_obs(a_i0, a_i1, a_s) & ~sa0) | sa1;
        out_b = (mux_obs(b_i0, b_i1, b_s) & ~sa0) | sa1;
    end

    always_comb begin
        m_busy  = sel ? b_busy  : a_busy;
        m_done  = sel ? b_done  : a_done;
        m_pass  = sel ? b_pass  : a_pass;
        m_mask  = sel ? b_mask  : a_mask;
        m_first = sel ? b_first : a_first;
        m_vec   = sel ? b_vec   : a_vec;
        m_stim  = sel ? {b_i0, b_i1, b_s} : {a_i0, a_i1, a_s};
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Vector-level reference: walk the 8 vectors, find mismatches, derive the done cycle.
    task automatic model(input bit stop, input logic [8:0] m0, input logic [8:0] m1,
                         output logic [8:0] mask, output logic [2:0] first,
                         output bit pass, output int done_cyc);
        int last;
        bit found;
        logic [8:0] good, mm;
        mask = '0; first = '0; found = 0; last = 7;
        for (int v = 0; v < 8; v++) begin
            good = mux_obs(v[2], v[1], v[0]);
            mm   = good ^ ((good & ~m0) | m1);
            mask |= mm;
            if (mm != 0 && !found) begin
                found = 1;
                first = 3'(v);
            end
            if (stop && mm != 0) begin
                last = v;
                break;
            end
        end
        pass     = (mask == 0);
        done_cyc = (last + 1) * (S + 1) + 1;
    endtask

    task automatic pulse_start(input bit s);
        if (s) start_b = 1'b1; else start_a = 1'b1;
    endtask

    task automatic run_case(input string tag, input bit s, input logic [8:0] m0,
                            input logic [8:0] m1, input logic [8:0] emask,
                            input logic [2:0] efirst, input bit epass, input int edone,
                            input bit inj);
        int ev;
        sel = s; sa0 = m0; sa1 = m1;
        @(negedge clk);
        pulse_start(s);
        @(posedge clk);
        for (int cyc = 1; cyc <= edone + 2; cyc++) begin
            @(negedge clk);
            start_a = 1'b0; start_b = 1'b0;
            if (inj && (cyc == 5 || cyc == 25)) pulse_start(s);
            chk($sformatf("%s busy c%0d", tag, cyc), m_busy, cyc <= edone);
            chk($sformatf("%s done c%0d", tag, cyc), m_done, cyc == edone);
            if (cyc < edone) begin
                ev = (cyc - 1) / (S + 1);
                chk($sformatf("%s stim c%0d", tag, cyc), m_stim, ev);
                chk($sformatf("%s vec c%0d", tag, cyc), m_vec, ev);
                chk($sformatf("%s pass_clr c%0d", tag, cyc), m_pass, 0);
            end else begin
                if (cyc > edone) chk($sformatf("%s stim_idle c%0d", tag, cyc), m_stim, 0);
                chk($sformatf("%s pass c%0d", tag, cyc), m_pass, epass);
                chk($sformatf("%s mask c%0d", tag, cyc), m_mask, emask);
                chk($sformatf("%s first c%0d", tag, cyc), m_first, efirst);
            end
        end
        start_a = 1'b0; start_b = 1'b0;
    endtask

    typedef struct {
        string      name;
        bit         s;
        logic [8:0] sa0, sa1, mask;
        logic [2:0] first;
        bit         pass;
        int         done;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [8:0] em, m0, m1;
        logic [2:0] ef;
        bit ep, rs;
        int ed;

        tbl[0] = '{"clean",     1'b0, 9'h000, 9'h000, 9'h000, 3'd0, 1'b1, 25};
        tbl[1] = '{"sa0_b8",    1'b0, 9'h100, 9'h000, 9'h100, 3'd3, 1'b0, 25};
        tbl[2] = '{"b5s1_b6s0", 1'b0, 9'h040, 9'h020, 9'h060, 3'd1, 1'b0, 25};
        tbl[3] = '{"stop_b0s1", 1'b1, 9'h000, 9'h001, 9'h001, 3'd0, 1'b0, 4};
        tbl[4] = '{"stop_b8s0", 1'b1, 9'h100, 9'h000, 9'h100, 3'd3, 1'b0, 13};
        tbl[5] = '{"b2s1",      1'b0, 9'h000, 9'h004, 9'h004, 3'd0, 1'b0, 25};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst busy", a_busy, 0);
        chk("rst done", a_done, 0);
        chk("rst pass", a_pass, 0);
        chk("rst mask", a_mask, 0);
        chk("rst stim", {a_i0, a_i1, a_s}, 0);
        chk("rst stop busy", b_busy, 0);
        rst = 1'b0;

        foreach (tbl[i])
            run_case(tbl[i].name, tbl[i].s, tbl[i].sa0, tbl[i].sa1, tbl[i].mask,
                     tbl[i].first, tbl[i].pass, tbl[i].done, 1'b0);

        // Starts in WAIT and in DONE are ignored
        run_case("ignore_start", 1'b0, 9'h000, 9'h000, 9'h000, 3'd0, 1'b1, 25, 1'b1);

        // Reset mid-run aborts and clears everything immediately
        sel = 1'b0; sa0 = '0; sa1 = 9'h020;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc < 10; cyc++) begin
            @(negedge clk);
            start_a = 1'b0;
        end
        rst = 1'b1;
        #1;
        chk("midrst busy", a_busy, 0);
        chk("midrst mask", a_mask, 0);
        chk("midrst stim", {a_i0, a_i1, a_s}, 0);
        chk("midrst vec", a_vec, 0);
        chk("midrst first", a_first, 0);
        @(negedge clk);
        rst = 1'b0;
        run_case("after_rst", 1'b0, 9'h000, 9'h000, 9'h000, 3'd0, 1'b1, 25, 1'b0);

        // Back-to-back with start held high
        sel = 1'b0; sa0 = '0; sa1 = '0;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 52; cyc++) begin
            @(negedge clk);
            if (cyc == 25 || cyc == 51) chk($sformatf("b2b done c%0d", cyc), a_done, 1);
            if (cyc == 26) chk("b2b gap busy", a_busy, 0);
            if (cyc == 27) chk("b2b rerun busy", a_busy, 1);
            if (cyc == 40) chk("b2b done_mid", a_done, 0);
            if (cyc == 51) chk("b2b pass", a_pass, 1);
            if (cyc == 52) start_a = 1'b0;
        end
        @(negedge clk);
        chk("b2b idle", a_busy, 0);

        // Randomized single/double stuck-at faults against the model
        for (int n = 0; n < 16; n++) begin
            rs = 1'($urandom_range(0, 1));
            m0 = ($urandom_range(0, 2) == 0) ? 9'h000 : 9'(1 << $urandom_range(0, 8));
            m1 = ($urandom_range(0, 2) == 0) ? 9'h000 : 9'(1 << $urandom_range(0, 8));
            model(rs, m0, m1, em, ef, ep, ed);
            run_case($sformatf("rnd%0d", n), rs, m0, m1, em, ef, ep, ed, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_selftest_ctrl.md
# mux_selftest_ctrl

Built-in self-test sequencer for the `mux_proper` 2:1 multiplexer and its 9-wire observation bus. On `start` it drives all eight `{I0,I1,S}` combinations into the mux and waits a programmable settle time per vector. It then compares the 9-bit `out` vector against an internally computed golden vector and accumulates a per-wire fault mask. It replaces bench-only checking with a synthesizable controller that sits beside `mux_proper` and reports pass/fail plus suspect wires to the top level.

## Interface
- `SETTLE_CYCLES`, 2: cycles each vector is held before comparison; legal range 1..15.
- `STOP_ON_FAIL`, 0: 1 ends the run at the first mismatching vector; 0 runs all 8 vectors.

- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  run request; sampled only in IDLE.
- `dut_out`  in  9  observation bus from `mux_proper.out`.
- `dut_i0`, `dut_i1`, `dut_s`  out  1 each  registered stimulus to `mux_proper` I0/I1/S.
- `busy`  out  1  high from the cycle after `start` is accepted through the DONE cycle.
- `done`  out  1  one-cycle pulse in the DONE state.
- `pass`  out  1  1 when the last run had no mismatch; valid from `done`, held until next accepted `start`.
- `fail_mask`  out  9  OR of `dut_out ^ golden` over all checked vectors; held like `pass`.
- `first_fail_vec`  out  3  index of the first mismatching vector; 0 when `pass`=1.
- `vec_idx`  out  3  current vector index, for debug.

## Operation
- Vector index v encodes `{I0,I1,S}` = `{v[2],v[1],v[0]}`, applied in order 0..7. `dut_*` outputs are driven directly from the v register.
- Golden vector:
  - g[0]=I0, g[1]=I1.
  - g[2]=g[3]=g[4]=S, g[5]=~S.
  - g[6]=I1&S, g[7]=I0&~S, g[8]=g[6]|g[7].
- States:
  - IDLE: v=0, so stimulus is 0/0/0. `start`=1 clears `fail_mask`, `pass`, `first_fail_vec` and loads the settle counter with SETTLE_CYCLES, then goes to WAIT.
  - WAIT: decrement the counter; at 1, go to CHECK.
  - CHECK: compute mism = `dut_out ^ golden(v)` and OR it into `fail_mask`. If mism≠0 and this is the first failure, record v in `first_fail_vec`. Go to DONE if v==7, or if STOP_ON_FAIL and mism≠0. Otherwise increment v, reload the counter, and go to WAIT.
  - DONE: `done`=1. `pass` = (`fail_mask`==0), using the mask value including the last CHECK. Reset v to 0 and go to IDLE.
- `start` in WAIT, CHECK or DONE is ignored; there is no queuing.
- Reset: state IDLE, v=0, and every output 0 (`pass`=0, `fail_mask`=0, `done`=0, `busy`=0, stimulus 0/0/0). A reset mid-run aborts the run and discards partial results.
- `dut_out` is used only in CHECK and is assumed combinationally stable after SETTLE_CYCLES.

## Timing
- `start` accepted at edge 0. Vector v is checked in cycle (v+1)·(SETTLE_CYCLES+1).
- A full run with SETTLE_CYCLES=2 has the last CHECK in cycle 24, `done` high in cycle 25, and IDLE again in cycle 26. In general, `done` is high in cycle 8·(SETTLE_CYCLES+1)+1.
- The stimulus changes on the edge that ends CHECK, so each vector is held for exactly SETTLE_CYCLES+1 cycles.
- An early stop after a failing CHECK in cycle n puts `done` in cycle n+1.
- Back-to-back runs: `start` held high continuously is accepted in the first IDLE cycle after DONE, giving a 1-cycle gap between `done` and the next `busy`.

## Test plan
- Fault-free `mux_proper`, SETTLE_CYCLES=2, `start` pulse: `done` in cycle 25, `pass`=1, `fail_mask`=9'h000, `first_fail_vec`=0.
- `dut_out[8]` forced stuck-at-0: first mismatch at v=3 (I1=1, S=1). Result: `pass`=0, `fail_mask`=9'b100000000, `first_fail_vec`=3.
- `dut_out[5]` stuck-at-1 and `dut_out[6]` stuck-at-0: mismatches begin at v=1 and v=3. Result: `fail_mask`=9'b001100000, `first_fail_vec`=1.
- STOP_ON_FAIL=1 with `dut_out[0]` stuck-at-1: mismatch at v=0 gives CHECK in cycle 3 and `done` in cycle 4. Result: `fail_mask`=9'b000000001, `first_fail_vec`=0.
- `rst` asserted in cycle 10 of a run: outputs go to 0 immediately and the stimulus returns to 0/0/0. A new `start` then completes a normal 25-cycle run.
- `start` pulsed in cycles 5 and 25 during a run: both are ignored, and only one `done` occurs, in cycle 25.
